dmem_access_ctrl: RTL and testbench

- Memory-stage data-bus master. Consumes the mem-stage controls produced by the pipeline controller (memenM, memwriteM, alucontrolM) together with the M-stage address and store data.
- Issues one SRAM-like request (req/addr_ok/data_ok) per memory instruction.
- Stalls the pipeline until the transaction completes, then returns the aligned, sign/zero-extended load result to the M/W path.
- Drains in-flight transactions cleanly when the M stage is flushed.

---
 rtl/dmem_access_ctrl_if.sv | 34 +++
 rtl/dmem_access_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// dmem_access_ctrl_if
// SRAM-like data bus between the memory-stage controller and data memory.
//   data_req     : master -> slave, request valid (held until data_addr_ok)
//   data_wr      : master -> slave, 1 = write, 0 = read
//   data_size    : master -> slave, 0 = byte, 1 = half, 2 = word
//   data_addr    : master -> slave, byte address
//   data_wdata   : master -> slave, write data (already lane-replicated)
//   data_wstrb   : master -> slave, byte strobes
//   data_addr_ok : slave -> master, request accepted this cycle
//   data_data_ok : slave -> master, read data valid / write acknowledged
//   data_rdata   : slave -> master, raw read word
// ---------------------------------------------------------------------------
interface dmem_access_ctrl_if;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [3:0]  data_wstrb;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;

   modport master (
      output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
      input  data_addr_ok, data_data_ok, data_rdata
   );

   modport slave (
      input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
      output data_addr_ok, data_data_ok, data_rdata
   );
endinterface

// File: rtl/dmem_access_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_access_ctrl
// Memory-stage data-bus master. Issues one bus transaction per memory
// instruction in M, stalls the pipeline until it completes, and returns the
// aligned, sign/zero-extended load result.
//   clk, rst     : clock, asynchronous active-low reset
//   memenM       : memory access present in M
//   memwriteM    : byte write strobes (nonzero = store), already aligned
//   alucontrolM  : load type selector
//   addrM        : effective address (alignment checked upstream)
//   writedataM   : store data, lane-replicated
//   flushM       : M stage flushed; in-flight access completes but is dropped
//   stall_other  : another stall source holds M (keeps FSM in DONE)
//   bus          : SRAM-like data bus, master side
//   readdataM    : extended load result, held until the next captured load
//   mem_stall    : hold F..M stages while an access is outstanding
// ---------------------------------------------------------------------------
module dmem_access_ctrl #(
   parameter logic [7:0] OP_LB  = 8'hE0,
   parameter logic [7:0] OP_LBU = 8'hE1,
   parameter logic [7:0] OP_LH  = 8'hE2,
   parameter logic [7:0] OP_LHU = 8'hE3,
   parameter logic [7:0] OP_LW  = 8'hE4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      memenM,
   input  logic [3:0]                memwriteM,
   input  logic [7:0]                alucontrolM,
   input  logic [31:0]               addrM,
   input  logic [31:0]               writedataM,
   input  logic                      flushM,
   input  logic                      stall_other,
   dmem_access_ctrl_if.master        bus,
   output logic [31:0]               readdataM,
   output logic                      mem_stall
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t      state_reg, state_next;
   logic        cancel_reg, cancel_next;
   logic [31:0] readdata_reg, readdata_next;

   // Request fields captured while in IDLE, replayed during REQ/WAIT so the
   // bus stays stable even if the M inputs change underneath.
   logic        wr_reg;
   logic [1:0]  size_reg;
   logic [31:0] addr_reg;
   logic [31:0] wdata_reg;
   logic [3:0]  wstrb_reg;
   logic [7:0]  op_reg;

   logic        in_wr;
   logic [1:0]  in_size;
   logic [3:0]  in_wstrb;
   logic [2:0]  strb_cnt;
   logic        issue;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_ext;

   // ---------------- request decode from the M inputs ----------------
   always_comb begin
      strb_cnt = {2'b00, memwriteM[0]} + {2'b00, memwriteM[1]}
               + {2'b00, memwriteM[2]} + {2'b00, memwriteM[3]};
      in_wr    = |memwriteM;
      in_wstrb = 4'b1111;
      in_size  = 2'd2;
      if (in_wr) begin
         in_wstrb = memwriteM;
         case (strb_cnt)
            3'd1:    in_size = 2'd0;
            3'd2:    in_size = 2'd1;
            default: in_size = 2'd2;
         endcase
      end else begin
         case (alucontrolM)
            OP_LB, OP_LBU: in_size = 2'd0;
            OP_LH, OP_LHU: in_size = 2'd1;
            default:       in_size = 2'd2;
         endcase
      end
   end

   // rst is folded in so the bus and stall stay quiet during reset even if
   // memenM is asserted.
   assign issue = (state_reg == IDLE) & memenM & ~flushM & rst;

   always_comb begin
      bus.data_req = issue | (state_reg == REQ);
      mem_stall    = issue | (state_reg == REQ) | (state_reg == WAIT);
      if (state_reg == IDLE) begin
         bus.data_wr    = in_wr;
         bus.data_size  = in_size;
         bus.data_addr  = addrM;
         bus.data_wdata = writedataM;
         bus.data_wstrb = in_wstrb;
      end else begin
         bus.data_wr    = wr_reg;
         bus.data_size  = size_reg;
         bus.data_addr  = addr_reg;
         bus.data_wdata = wdata_reg;
         bus.data_wstrb = wstrb_reg;
      end
   end

   // ---------------- load alignment and extension ----------------
   always_comb begin
      case (addr_reg[1:0])
         2'd0:    byte_sel = bus.data_rdata[7:0];
         2'd1:    byte_sel = bus.data_rdata[15:8];
         2'd2:    byte_sel = bus.data_rdata[23:16];
         default: byte_sel = bus.data_rdata[31:24];
      endcase
      half_sel = addr_reg[1] ? bus.data_rdata[31:16] : bus.data_rdata[15:0];
      case (op_reg)
         OP_LB:   load_ext = {{24{byte_sel[7]}}, byte_sel};
         OP_LBU:  load_ext = {24'd0, byte_sel};
         OP_LH:   load_ext = {{16{half_sel[15]}}, half_sel};
         OP_LHU:  load_ext = {16'd0, half_sel};
         default: load_ext = bus.data_rdata;
      endcase
   end

   // ---------------- next state ----------------
   always_comb begin
      state_next    = state_reg;
      cancel_next   = cancel_reg;
      readdata_next = readdata_reg;
      case (state_reg)
         IDLE: begin
            cancel_next = 1'b0;
            if (issue)
               state_next = bus.data_addr_ok ? WAIT : REQ;
         end
         REQ: begin
            // The request is never withdrawn once raised; a flush only
            // marks the result for discard.
            if (flushM)
               cancel_next = 1'b1;
            if (bus.data_addr_ok)
               state_next = WAIT;
         end
         WAIT: begin
            if (flushM)
               cancel_next = 1'b1;
            if (bus.data_data_ok) begin
               // A flush arriving in the completion cycle itself still drops
               // the result.
               if (cancel_reg | flushM) begin
                  state_next  = IDLE;
                  cancel_next = 1'b0;
               end else begin
                  state_next = DONE;
                  if (!wr_reg)
                     readdata_next = load_ext;
               end
            end
         end
         DONE: begin
            if (flushM || !stall_other)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // ---------------- registers ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= IDLE;
         cancel_reg   <= 1'b0;
         readdata_reg <= 32'd0;
      end else begin
         state_reg    <= state_next;
         cancel_reg   <= cancel_next;
         readdata_reg <= readdata_next;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_reg    <= 1'b0;
         size_reg  <= 2'd0;
         addr_reg  <= 32'd0;
         wdata_reg <= 32'd0;
         wstrb_reg <= 4'd0;
         op_reg    <= 8'd0;
      end else if (state_reg == IDLE) begin
         wr_reg    <= in_wr;
         size_reg  <= in_size;
         addr_reg  <= addrM;
         wdata_reg <= writedataM;
         wstrb_reg <= in_wstrb;
         op_reg    <= alucontrolM;
      end
   end

   assign readdataM = readdata_reg;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dmem_access_ctrl
// Drives M-stage accesses with a scripted bus responder. Expected load
// results (or the unchanged value for stores) are queued at issue and
// popped when the DUT reports completion (first DONE cycle).
// ---------------------------------------------------------------------------
module tb_dmem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        memenM;
   logic [3:0]  memwriteM;
   logic [7:0]  alucontrolM;
   logic [31:0] addrM;
   logic [31:0] writedataM;
   logic        flushM;
   logic        stall_other;
   logic [31:0] readdataM;
   logic        mem_stall;

   dmem_access_ctrl_if bus();

   dmem_access_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .memenM      (memenM),
      .memwriteM   (memwriteM),
      .alucontrolM (alucontrolM),
      .addrM       (addrM),
      .writedataM  (writedataM),
      .flushM      (flushM),
      .stall_other (stall_other),
      .bus         (bus),
      .readdataM   (readdataM),
      .mem_stall   (mem_stall)
   );

   always #5 clk = ~clk;

   int          checks   = 0;
   int          failures = 0;
   int          txn      = 0;
   logic [31:0] model_rd = 32'd0;
   logic [31:0] exp_q[$];
   logic [7:0]  rand_ops[6] = '{8'hE0, 8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'h3C};

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h (txn %0d, t=%0t)", tag, got, exp, txn, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   function automatic logic [31:0] model_ext(input logic [7:0] op, input logic [1:0] a,
                                             input logic [31:0] d);
      logic [7:0]  b;
      logic [15:0] h;
      b = d[int'(a) * 8 +: 8];
      h = a[1] ? d[31:16] : d[15:0];
      case (op)
         8'hE0:   return {{24{b[7]}}, b};
         8'hE1:   return {24'd0, b};
         8'hE2:   return {{16{h[15]}}, h};
         8'hE3:   return {16'd0, h};
         default: return d;
      endcase
   endfunction

   function automatic logic [1:0] model_size(input logic [3:0] strb, input logic [7:0] op);
      int n;
      n = int'(strb[0]) + int'(strb[1]) + int'(strb[2]) + int'(strb[3]);
      if (strb != 4'd0) return (n == 1) ? 2'd0 : (n == 2) ? 2'd1 : 2'd2;
      if (op == 8'hE0 || op == 8'hE1) return 2'd0;
      if (op == 8'hE2 || op == 8'hE3) return 2'd1;
      return 2'd2;
   endfunction

   // One complete access. addr_wait = REQ cycles before addr_ok (0 = accepted
   // in the issue cycle); data_wait = cycles after acceptance until data_ok;
   // flush_j > 0 pulses flushM in that WAIT cycle; hold = DONE cycles with
   // stall_other high.
   task automatic do_access(input logic [3:0] strb, input logic [7:0] op,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input int addr_wait,
                            input int data_wait, input int flush_j, input int hold);
      logic        is_st;
      logic [1:0]  exp_size;
      logic [3:0]  exp_wstrb;
      logic [31:0] e;
      is_st     = (strb != 4'd0);
      exp_size  = model_size(strb, op);
      exp_wstrb = is_st ? strb : 4'b1111;
      txn++;
      $display("txn %0d: %s op=%h strb=%b addr=%h rdata=%h aw=%0d dw=%0d flush=%0d hold=%0d",
               txn, is_st ? "store" : "load ", op, strb, addr, rdata,
               addr_wait, data_wait, flush_j, hold);

      // issue cycle (IDLE)
      step();
      memenM = 1'b1; memwriteM = strb; alucontrolM = op; addrM = addr;
      writedataM = wdata; flushM = 1'b0; stall_other = 1'b0;
      bus.data_addr_ok = (addr_wait == 0); bus.data_data_ok = 1'b0;
      bus.data_rdata = $urandom;
      sample();
      check_value("rd_before", readdataM, model_rd);
      check_value("issue_req", 32'(bus.data_req), 32'd1);
      check_value("issue_stall", 32'(mem_stall), 32'd1);
      check_value("issue_wr", 32'(bus.data_wr), 32'(is_st));
      check_value("issue_size", 32'(bus.data_size), 32'(exp_size));
      check_value("issue_wstrb", 32'(bus.data_wstrb), 32'(exp_wstrb));
      check_value("issue_addr", bus.data_addr, addr);
      if (is_st) check_value("issue_wdata", bus.data_wdata, wdata);

      // scoreboard entry for the completion
      if (flush_j <= 0) begin
         if (!is_st) model_rd = model_ext(op, addr[1:0], rdata);
         exp_q.push_back(model_rd);
      end

      // REQ cycles; M inputs scrambled to prove the bus replays the latch
      for (int i = 1; i <= addr_wait; i++) begin
         step();
         addrM = ~addr; writedataM = ~wdata;
         bus.data_addr_ok = (i == addr_wait);
         sample();
         check_value("req_req", 32'(bus.data_req), 32'd1);
         check_value("req_stall", 32'(mem_stall), 32'd1);
         check_value("req_wr", 32'(bus.data_wr), 32'(is_st));
         check_value("req_size", 32'(bus.data_size), 32'(exp_size));
         check_value("req_wstrb", 32'(bus.data_wstrb), 32'(exp_wstrb));
         check_value("req_addr", bus.data_addr, addr);
         if (is_st) check_value("req_wdata", bus.data_wdata, wdata);
      end

      // WAIT cycles
      for (int j = 1; j <= data_wait; j++) begin
         step();
         addrM = ~addr;
         bus.data_addr_ok = 1'b0;
         bus.data_data_ok = (j == data_wait);
         bus.data_rdata   = (j == data_wait) ? rdata : $urandom;
         flushM = (j == flush_j);
         if (flush_j > 0 && j > flush_j) memenM = 1'b0;
         sample();
         check_value("wait_req", 32'(bus.data_req), 32'd0);
         check_value("wait_stall", 32'(mem_stall), 32'd1);
      end

      // a cancelled access goes straight back to IDLE; the next issue
      // cycle verifies that and the unchanged readdataM
      if (flush_j > 0) return;

      // DONE cycles
      e = 32'd0;
      for (int k = 0; k <= hold; k++) begin
         step();
         bus.data_data_ok = 1'b0;
         bus.data_rdata   = $urandom;
         stall_other      = (k < hold);
         sample();
         check_value("done_stall", 32'(mem_stall), 32'd0);
         check_value("done_req", 32'(bus.data_req), 32'd0);
         if (k == 0) begin
            if (exp_q.size() == 0) begin
               check_value("sb_nonempty", 32'd0, 32'd1);
            end else begin
               e = exp_q.pop_front();
               check_value("done_rdata", readdataM, e);
            end
         end else begin
            check_value("hold_rdata", readdataM, e);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      memenM = 1'b0; memwriteM = 4'd0; alucontrolM = 8'd0; addrM = 32'd0;
      writedataM = 32'd0; flushM = 1'b0; stall_other = 1'b0;
      bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = 32'd0;

      // reset state
      #2;
      check_value("rst_req", 32'(bus.data_req), 32'd0);
      check_value("rst_stall", 32'(mem_stall), 32'd0);
      check_value("rst_rdata", readdataM, 32'd0);
      step();
      step();
      rst = 1'b1;
      step();

      // zero-wait word load
      do_access(4'b0000, 8'hE4, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 0, 1, 0, 0);
      // byte / half extension
      do_access(4'b0000, 8'hE0, 32'h0000_0102, 32'd0, 32'h1280_3456, 0, 1, 0, 0);
      do_access(4'b0000, 8'hE1, 32'h0000_0102, 32'd0, 32'h1280_3456, 0, 1, 0, 0);
      do_access(4'b0000, 8'hE2, 32'h0000_0102, 32'd0, 32'h8001_0000, 0, 1, 0, 0);
      do_access(4'b0000, 8'hE3, 32'h0000_0100, 32'd0, 32'h1234_F00D, 0, 1, 0, 0);
      // store with delayed acceptance
      do_access(4'b1100, 8'h00, 32'h0000_0202, 32'hBEEF_BEEF, 32'hFFFF_FFFF, 3, 1, 0, 0);
      // flush in WAIT, then an immediate new load (must issue from IDLE)
      do_access(4'b0000, 8'hE4, 32'h0000_0400, 32'd0, 32'h0000_0055, 0, 3, 1, 0);
      do_access(4'b0000, 8'hE0, 32'h0000_0103, 32'd0, 32'h7F00_0000, 1, 2, 0, 3);
      // flush on the completion cycle itself
      do_access(4'b0000, 8'hE4, 32'h0000_0500, 32'd0, 32'h1111_2222, 1, 2, 2, 0);
      // byte and word stores, unknown load code treated as word
      do_access(4'b0001, 8'h00, 32'h0000_0300, 32'h5A5A_5A5A, 32'd0, 0, 2, 0, 1);
      do_access(4'b1111, 8'h00, 32'h0000_0304, 32'hCAFE_F00D, 32'd0, 2, 1, 0, 0);
      do_access(4'b0000, 8'h3C, 32'h0000_0308, 32'd0, 32'h0BAD_C0DE, 0, 1, 0, 0);

      // randomised loads
      for (int r = 0; r < 8; r++) begin
         logic [7:0]  op;
         logic [31:0] a;
         op = rand_ops[$urandom_range(0, 5)];
         a  = $urandom & 32'h0000_FFFF;
         if (op == 8'hE2 || op == 8'hE3) a[0] = 1'b0;
         else if (op != 8'hE0 && op != 8'hE1) a[1:0] = 2'b00;
         do_access(4'b0000, op, a, 32'd0, $urandom, $urandom_range(0, 2),
                   $urandom_range(1, 3), 0, $urandom_range(0, 2));
      end

      // asynchronous reset while in REQ
      txn++;
      $display("txn %0d: load held in REQ, then async reset", txn);
      step();
      memenM = 1'b1; memwriteM = 4'd0; alucontrolM = 8'hE4; addrM = 32'h40;
      bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
      sample();
      check_value("ar_issue_req", 32'(bus.data_req), 32'd1);
      step();
      sample();
      check_value("ar_req_req", 32'(bus.data_req), 32'd1);
      #1;
      rst = 1'b0;
      #1;
      check_value("ar_req_drop", 32'(bus.data_req), 32'd0);
      check_value("ar_stall_drop", 32'(mem_stall), 32'd0);
      check_value("ar_rdata_clr", readdataM, 32'd0);
      model_rd = 32'd0;
      step();
      check_value("ar_hold_req", 32'(bus.data_req), 32'd0);
      // release with a stray data_ok that must be ignored
      rst = 1'b1; memenM = 1'b0;
      bus.data_data_ok = 1'b1; bus.data_rdata = 32'hFFFF_FFFF;
      step();
      bus.data_data_ok = 1'b0;
      sample();
      check_value("ar_stray_rdata", readdataM, 32'd0);
      check_value("ar_stray_stall", 32'(mem_stall), 32'd0);
      do_access(4'b0000, 8'hE4, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 0, 1, 0, 0);

      // idle tail
      step();
      memenM = 1'b0; memwriteM = 4'd0;
      sample();
      check_value("tail_stall", 32'(mem_stall), 32'd0);
      check_value("tail_req", 32'(bus.data_req), 32'd0);
      check_value("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
